// File: rtl/store_ram.sv
// Byte-addressed data memory with a big-endian, one-byte-per-clock store engine
// and a combinational big-endian word read port.
module store_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [2:0]        r_n;
  logic [2:0]        r_k;
  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  logic [7:0] r_mem [DEPTH] = '{default: 8'h00};

  logic [1:0]        w_sel;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_last;
  logic              w_wen;

  // Byte k of an n-byte store is data byte n-1-k: MSB lands at the lowest address.
  assign w_sel     = r_n[1:0] - 2'd1 - r_k[1:0];
  assign w_byte    = r_data[{w_sel, 3'b000} +: 8];
  assign w_wr_addr = r_addr + ADDR_W'(r_k);
  assign w_last    = (r_k == r_n - 3'd1);
  assign w_wen     = (r_state == S_WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (req_valid && r_ready) begin
            r_addr  <= req_addr;
            r_data  <= req_data;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            unique case (req_size)
              2'b00: begin
                r_n     <= 3'd1;
                r_state <= S_WRITE;
              end
              2'b01: begin
                r_n     <= 3'd2;
                r_state <= S_WRITE;
              end
              2'b10: begin
                r_n     <= 3'd4;
                r_state <= S_WRITE;
              end
              default: begin
                r_n     <= 3'd0;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_k <= r_k + 3'd1;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Memory contents survive reset; only the engine state is cleared.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      r_mem[w_wr_addr] <= w_byte;
    end
  end

  assign req_ready = r_ready;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = r_busy;

  assign rd_data = {r_mem[rd_addr],
                    r_mem[rd_addr + ADDR_W'(1)],
                    r_mem[rd_addr + ADDR_W'(2)],
                    r_mem[rd_addr + ADDR_W'(3)]};

endmodule

// File: tb/tb_store_ram.sv
// Directed bench for store_ram: expected done latency and err are queued when
// a store is issued and checked when the engine reports completion.
module tb_store_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_data;
  logic        done;
  logic        err;
  logic        busy;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  int   q_lat [$];
  logic q_err [$];

  store_ram #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  // Called just after the accept edge; pops the expected latency/err.
  task automatic wait_done(input string tag);
    int   cnt;
    int   lat;
    logic e;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    lat = q_lat.pop_front();
    e   = q_err.pop_front();
    check({tag, "_lat"}, 32'(cnt + 1), 32'(lat));
    check({tag, "_err"}, 32'(err), 32'(e));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [7:0] a,
                          input logic [1:0] sz, input logic [31:0] d);
    int lat;
    unique case (sz)
      2'b00:   lat = 2;
      2'b01:   lat = 3;
      2'b10:   lat = 5;
      default: lat = 1;
    endcase
    q_lat.push_back(lat);
    q_err.push_back(sz == 2'b11);
    @(negedge clk);
    check({tag, "_rdy0"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_size  = 2'($urandom);
    req_data  = $urandom;
    wait_done(tag);
  endtask

  initial begin
    int lows;
    int dn;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_data  = '0;
    rd_addr   = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd_check("rst_mem", 8'h00, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_store("word", 8'h10, 2'b10, 32'h12345678);
    rd_check("word_rd10", 8'h10, 32'h12345678);
    rd_check("word_rd11", 8'h11, 32'h34567800);

    do_store("mw", 8'h20, 2'b10, 32'hAABBCCDD);
    do_store("mh", 8'h21, 2'b01, 32'h1234BEEF);
    rd_check("merge_h", 8'h20, 32'hAABEEFDD);
    do_store("mb", 8'h23, 2'b00, 32'hFFFFFF77);
    rd_check("merge_b", 8'h20, 32'hAABEEF77);

    do_store("wrap", 8'hFE, 2'b10, 32'hCAFEF00D);
    rd_check("wrap_fe", 8'hFE, 32'hCAFEF00D);
    rd_check("wrap_00", 8'h00, 32'hF00D0000);
    rd_check("wrap_ff", 8'hFF, 32'hFEF00D00);

    do_store("rsv", 8'h50, 2'b11, 32'hDEADBEEF);
    rd_check("rsv_mem", 8'h50, 32'h0);

    // Reset two edges into a word store: only the first two bytes land.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 8'h40;
    req_size  = 2'b10;
    req_data  = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dn = 0;
    @(posedge clk);
    #1;
    rd_check("mid_e1", 8'h40, 32'h11000000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mr_ready", 32'(req_ready), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dn++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dn++;
    end
    check("mr_nodone", 32'(dn), 32'd0);
    rd_check("mr_mem", 8'h40, 32'h11220000);

    // Back-to-back word stores with req_valid held high.
    q_lat.push_back(5);
    q_err.push_back(1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 8'h60;
    req_size  = 2'b10;
    req_data  = 32'h01020304;
    @(posedge clk);
    #1;
    req_addr = 8'h64;
    req_data = 32'hA1B2C3D4;
    lows = 0;
    while (req_ready !== 1'b1 && lows < 20) begin
      lows++;
      @(posedge clk);
      #1;
    end
    check("b2b_lows", 32'(lows), 32'd5);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done("b2b");
    rd_check("b2b_a", 8'h60, 32'h01020304);
    rd_check("b2b_b", 8'h64, 32'hA1B2C3D4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
